// File: rtl/decay_sweep_scheduler.sv
// Shares one exponent-shift decay datapath across NUM_NEURONS stored membrane potentials.
// Each timestep_start sweeps every neuron (read, decay, write back) and streams the results.
module decay_sweep_scheduler #(
    parameter int NUM_NEURONS = 10,
    parameter int ADDR_W      = 4
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              timestep_start,
    input  logic              init_valid,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [31:0]       init_potential,
    input  logic [3:0]        init_decay_rate,
    output logic              init_ready,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [31:0]       upd_potential,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_potential,
    output logic              busy,
    output logic              decayed_valid,
    output logic [ADDR_W-1:0] decayed_addr,
    output logic [31:0]       decayed_potential,
    output logic              sweep_done,
    output logic              overrun_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   N_LIM    = (ADDR_W+1)'(NUM_NEURONS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {IDLE, READ, DECAY, DONE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] idx, idx_next;
    logic [31:0]       pot  [DEPTH];
    logic [3:0]        rate [DEPTH];
    logic [31:0]       cur_pot;
    logic [1:0]        cur_k;
    logic [31:0]       decay_result;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < N_LIM;
    endfunction

    // Non one-hot rate codes deliberately fall back to no decay.
    function automatic logic [1:0] rate_to_k(input logic [3:0] code);
        case (code)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [31:0] decay(input logic [31:0] v, input logic [1:0] k);
        logic [7:0] e;
        e = v[30:23];
        if (k == 2'd0 || e == 8'hFF) return v;
        if (e <= {6'd0, k})          return {v[31], 31'd0};
        return {v[31], e - {6'd0, k}, v[22:0]};
    endfunction

    assign decay_result = decay(cur_pot, cur_k);
    assign busy         = (state != IDLE);
    assign init_ready   = (state == IDLE);
    assign upd_ready    = (state == IDLE) && !init_valid;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (timestep_start) begin
                    state_next = READ;
                    idx_next   = '0;
                end
            end
            READ:  state_next = DECAY;
            DECAY: begin
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    state_next = READ;
                    idx_next   = idx + ADDR_W'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Register file: host writes only land in IDLE, so they never collide with write-back.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pot[i]  <= '0;
                rate[i] <= 4'b0001;
            end
        end else if (state == IDLE) begin
            if (init_valid) begin
                if (in_range(init_addr)) begin
                    pot[init_addr]  <= init_potential;
                    rate[init_addr] <= init_decay_rate;
                end
            end else if (upd_valid && in_range(upd_addr)) begin
                pot[upd_addr] <= upd_potential;
            end
        end else if (state == DECAY) begin
            pot[idx] <= decay_result;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cur_pot           <= '0;
            cur_k             <= '0;
            rd_potential      <= '0;
            decayed_valid     <= 1'b0;
            decayed_addr      <= '0;
            decayed_potential <= '0;
            sweep_done        <= 1'b0;
            overrun_err       <= 1'b0;
        end else begin
            rd_potential  <= pot[rd_addr];
            decayed_valid <= (state == DECAY);
            sweep_done    <= (state == DONE);
            if (state == READ) begin
                cur_pot <= pot[idx];
                cur_k   <= rate_to_k(rate[idx]);
            end
            if (state == DECAY) begin
                decayed_addr      <= idx;
                decayed_potential <= decay_result;
            end
            if (timestep_start && state != IDLE) begin
                overrun_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_decay_sweep_scheduler.sv
// Randomized and directed bench for decay_sweep_scheduler against a sweep-level model
// that precomputes every strobe of a sweep when it is launched.
module tb_decay_sweep_scheduler;

    localparam int N  = 10;
    localparam int AW = 4;

    logic          CLK, RST_n;
    logic          timestep_start;
    logic          init_valid;
    logic [AW-1:0] init_addr;
    logic [31:0]   init_potential;
    logic [3:0]    init_decay_rate;
    logic          init_ready;
    logic          upd_valid;
    logic [AW-1:0] upd_addr;
    logic [31:0]   upd_potential;
    logic          upd_ready;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_potential;
    logic          busy;
    logic          decayed_valid;
    logic [AW-1:0] decayed_addr;
    logic [31:0]   decayed_potential;
    logic          sweep_done;
    logic          overrun_err;

    decay_sweep_scheduler #(.NUM_NEURONS(N), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST_n(RST_n), .timestep_start(timestep_start),
        .init_valid(init_valid), .init_addr(init_addr), .init_potential(init_potential),
        .init_decay_rate(init_decay_rate), .init_ready(init_ready),
        .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_potential(upd_potential),
        .upd_ready(upd_ready), .rd_addr(rd_addr), .rd_potential(rd_potential),
        .busy(busy), .decayed_valid(decayed_valid), .decayed_addr(decayed_addr),
        .decayed_potential(decayed_potential), .sweep_done(sweep_done),
        .overrun_err(overrun_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // ---------------- behavioural model ----------------
    typedef struct { int cyc; logic [AW-1:0] addr; logic [31:0] val; } strobe_t;
    strobe_t     exp_q[$];
    int          done_q[$];
    logic [31:0] m_pot  [N];
    logic [3:0]  m_rate [N];
    int          cyc;
    int          s0;
    bit          active;
    bit          exp_overrun;
    bit          rd_chk;
    logic [31:0] exp_rd;
    logic [31:0] last_decayed [16];

    function automatic logic [31:0] m_decay(logic [31:0] v, logic [3:0] code);
        int k;
        int e;
        case (code)
            4'b0010: k = 1;
            4'b0100: k = 2;
            4'b1000: k = 3;
            default: k = 0;
        endcase
        e = int'(v[30:23]);
        if (k == 0 || e == 255) return v;
        if (e <= k) return {v[31], 31'd0};
        return v - (32'(k) << 23);
    endfunction

    function automatic bit m_busy();
        return active && cyc >= s0 && cyc <= s0 + 2*N;
    endfunction

    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < N; i++) begin
                m_pot[i]  = 32'd0;
                m_rate[i] = 4'b0001;
            end
            exp_q.delete();
            done_q.delete();
            cyc = 0; s0 = 0; active = 0;
            exp_overrun = 0; rd_chk = 1; exp_rd = 32'd0;
        end else begin
            bit idle_before;
            idle_before = !m_busy();
            rd_chk = idle_before;
            exp_rd = (int'(rd_addr) < N) ? m_pot[rd_addr] : 32'd0;
            if (idle_before) begin
                if (init_valid) begin
                    if (int'(init_addr) < N) begin
                        m_pot[init_addr]  = init_potential;
                        m_rate[init_addr] = init_decay_rate;
                    end
                end else if (upd_valid && int'(upd_addr) < N) begin
                    m_pot[upd_addr] = upd_potential;
                end
                if (timestep_start) begin
                    s0 = cyc + 1;
                    active = 1;
                    for (int i = 0; i < N; i++) begin
                        strobe_t s;
                        m_pot[i] = m_decay(m_pot[i], m_rate[i]);
                        s.cyc = s0 + 2*i + 2; s.addr = AW'(i); s.val = m_pot[i];
                        exp_q.push_back(s);
                    end
                    done_q.push_back(s0 + 2*N + 1);
                end
            end else if (timestep_start) begin
                exp_overrun = 1;
            end
            cyc = cyc + 1;
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge CLK) begin
        if (!RST_n) begin
            check("rst_busy", 32'(busy), 0);
            check("rst_dv", 32'(decayed_valid), 0);
            check("rst_done", 32'(sweep_done), 0);
            check("rst_overrun", 32'(overrun_err), 0);
            check("rst_rd", rd_potential, 0);
            check("rst_daddr", 32'(decayed_addr), 0);
            check("rst_dpot", decayed_potential, 0);
        end else begin
            bit ev, ed;
            ev = exp_q.size() > 0 && exp_q[0].cyc == cyc;
            ed = done_q.size() > 0 && done_q[0] == cyc;
            check("busy", 32'(busy), 32'(m_busy()));
            check("init_ready", 32'(init_ready), 32'(!m_busy()));
            check("upd_ready", 32'(upd_ready), 32'(!m_busy() && !init_valid));
            check("overrun_err", 32'(overrun_err), 32'(exp_overrun));
            check("decayed_valid", 32'(decayed_valid), 32'(ev));
            check("sweep_done", 32'(sweep_done), 32'(ed));
            if (ev) begin
                check("decayed_addr", 32'(decayed_addr), 32'(exp_q[0].addr));
                check("decayed_potential", decayed_potential, exp_q[0].val);
                void'(exp_q.pop_front());
            end
            if (ed) void'(done_q.pop_front());
            if (decayed_valid) last_decayed[decayed_addr] = decayed_potential;
            if (rd_chk) check("rd_potential", rd_potential, exp_rd);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic do_init(int a, logic [31:0] p, logic [3:0] r);
        init_valid = 1; init_addr = AW'(a); init_potential = p; init_decay_rate = r;
        step();
        init_valid = 0;
    endtask

    task automatic start_sweep();
        timestep_start = 1;
        step();
        timestep_start = 0;
    endtask

    // Leaves the caller at the negedge inside the sweep_done cycle.
    task automatic wait_done();
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge CLK);
            if (sweep_done) found = 1;
            else begin @(posedge CLK); #1; end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_done: sweep_done never seen within 60 cycles");
        end
    endtask

    function automatic logic [31:0] rand_pot();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 3))
            0: v[30:23] = 8'($urandom_range(0, 4));
            1: v[30:23] = 8'hFF;
            2: v[30:23] = 8'($urandom_range(100, 150));
            default: ;
        endcase
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        bit r;
        int waited;
        RST_n = 0; timestep_start = 0; init_valid = 0; init_addr = 0;
        init_potential = 0; init_decay_rate = 0; upd_valid = 0; upd_addr = 0;
        upd_potential = 0; rd_addr = 0;

        check("pin_rate2", m_decay(32'h411A147B, 4'b0010), 32'h409A147B);
        check("pin_e3", m_decay(32'h01800000, 4'b1000), 32'h00000000);
        check("pin_inf", m_decay(32'h7F800000, 4'b1000), 32'h7F800000);

        repeat (3) @(posedge CLK);
        @(negedge CLK) RST_n = 1;
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_init_ready", 32'(init_ready), 1);
        step();
        for (int a = 0; a < 16; a++) begin rd_addr = AW'(a); step(); end
        step();
        check("reset_readback", rd_potential, 32'd0);

        start_sweep(); wait_done(); step();
        check("zero_sweep_val9", last_decayed[9], 32'd0);

        do_init(9, 32'h411A147B, 4'b0010); start_sweep(); wait_done(); step();
        check("rate2", last_decayed[9], 32'h409A147B);
        do_init(9, 32'h411A147B, 4'b0100); start_sweep(); wait_done(); step();
        check("rate4", last_decayed[9], 32'h401A147B);
        do_init(9, 32'h411A147B, 4'b1000); start_sweep(); wait_done(); step();
        check("rate8", last_decayed[9], 32'h3F9A147B);
        do_init(9, 32'h411A147B, 4'b0101); start_sweep(); wait_done(); step();
        check("rate_bad", last_decayed[9], 32'h411A147B);

        do_init(0, 32'h01800000, 4'b1000);
        do_init(1, 32'h80800000, 4'b1000);
        do_init(2, 32'h7F800000, 4'b1000);
        start_sweep(); wait_done(); step();
        check("flush_e3", last_decayed[0], 32'h00000000);
        check("flush_neg", last_decayed[1], 32'h80000000);
        check("inf_pass", last_decayed[2], 32'h7F800000);

        init_valid = 1; init_addr = 3; init_potential = 32'h3F800000; init_decay_rate = 4'b0010;
        upd_valid = 1; upd_addr = 3; upd_potential = 32'hDEADBEEF;
        @(negedge CLK);
        check("both_init_ready", 32'(init_ready), 1);
        check("both_upd_ready", 32'(upd_ready), 0);
        @(posedge CLK); #1;
        init_valid = 0; upd_valid = 0;

        start_sweep();
        upd_valid = 1; upd_addr = 4; upd_potential = 32'h40400000;
        step(); step(); step();
        timestep_start = 1; step(); timestep_start = 0;
        @(negedge CLK);
        check("overrun_set", 32'(overrun_err), 1);
        @(posedge CLK); #1;
        waited = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK); r = upd_ready;
            @(posedge CLK); #1;
            if (r) break;
            waited++;
        end
        upd_valid = 0;
        check("upd_held_cycles", 32'(waited), 32'(2*N + 1 - 5));
        rd_addr = 4; step(); step();
        check("upd_readback", rd_potential, 32'h40400000);

        do_init(5, 32'h411A147B, 4'b0010);
        start_sweep(); wait_done();
        check("b2b_first", last_decayed[5], 32'h409A147B);
        timestep_start = 1; step(); timestep_start = 0;
        wait_done(); step();
        check("b2b_second", last_decayed[5], 32'h401A147B);
        rd_addr = 5; step(); step();
        check("b2b_readback", rd_potential, 32'h401A147B);

        for (int c = 0; c < 700; c++) begin
            init_valid = ($urandom_range(0, 3) == 0);
            init_addr = AW'($urandom_range(0, 15));
            init_potential = rand_pot();
            init_decay_rate = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) init_decay_rate = 4'(1 << $urandom_range(0, 3));
            upd_valid = ($urandom_range(0, 3) == 0);
            upd_addr = AW'($urandom_range(0, 15));
            upd_potential = rand_pot();
            rd_addr = AW'($urandom_range(0, 15));
            timestep_start = ($urandom_range(0, 24) == 0);
            step();
        end
        init_valid = 0; upd_valid = 0; timestep_start = 0;
        repeat (30) step();
        check("drain_strobes", 32'(exp_q.size()), 0);
        check("drain_done", 32'(done_q.size()), 0);

        do_init(6, 32'h42000000, 4'b0010);
        start_sweep();
        repeat (7) step();
        RST_n = 0; #1;
        check("async_busy", 32'(busy), 0);
        check("async_dv", 32'(decayed_valid), 0);
        check("async_done", 32'(sweep_done), 0);
        check("async_overrun", 32'(overrun_err), 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST_n = 1;
        step();
        for (int a = 0; a < N; a++) begin rd_addr = AW'(a); step(); end
        repeat (20) step();
        do_init(6, 32'h42000000, 4'b0010);
        start_sweep(); wait_done(); step();
        check("post_reset_sweep", last_decayed[6], 32'h41800000);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
